// File: rtl/sms_pkg.sv
// Shared types and GF(2^6) helpers for the iterative power S-box.
// Field arithmetic uses polynomial basis; reduction polynomial is passed in.
package sms_pkg;

    localparam int          SMS_FIELD_W = 6;
    localparam logic [6:0]  SMS_POLY    = 7'b1000011;
    localparam logic [5:0]  SMS_TMASK   = 6'b010100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sms_state_e;

    // Shift-and-add multiply; x^6 folds back onto the low polynomial bits.
    function automatic logic [5:0] gf6_mul(input logic [5:0] a,
                                           input logic [5:0] b,
                                           input logic [6:0] poly);
        logic [5:0] r;
        logic [5:0] aa;
        r  = '0;
        aa = a;
        for (int i = 0; i < 6; i++) begin
            if (b[i]) r = r ^ aa;
            aa = aa[5] ? ((aa << 1) ^ poly[5:0]) : (aa << 1);
        end
        return r;
    endfunction

    function automatic logic [5:0] gf6_sq(input logic [5:0] a, input logic [6:0] poly);
        return gf6_mul(a, a, poly);
    endfunction

    function automatic logic parity6(input logic [5:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/gf6_mul_red.sv
// Combinational GF(2^6) multiplier with reduction by POLY.
// Tie a and b together to use it as a squarer.
module gf6_mul_red
    import sms_pkg::*;
#(
    parameter logic [6:0] POLY = SMS_POLY
) (
    input  logic [5:0] a,
    input  logic [5:0] b,
    output logic [5:0] p
);

    assign p = gf6_mul(a, b, POLY);

endmodule

// File: rtl/sms_pow_iter.sv
// Iterative x^e XOR {6{t}} over GF(2^6), MSB-first square-and-multiply, one bit per clock.
// Define SMS_EARLY_EXIT_EN to skip leading zero exponent bits (results unchanged).
module sms_pow_iter
    import sms_pkg::*;
#(
    parameter int         EXP_W = 6,
    parameter logic [6:0] POLY  = SMS_POLY,
    parameter logic [5:0] TMASK = SMS_TMASK
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       x,
    input  logic [EXP_W-1:0] e,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [5:0]       y,
    output logic             busy
);

    localparam int CNT_W = (EXP_W > 1) ? $clog2(EXP_W) : 1;

    sms_state_e       state_q, state_d;
    logic [5:0]       x_q, x_d;
    logic [EXP_W-1:0] e_q, e_d;
    logic             t_q, t_d;
    logic [5:0]       acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [5:0]       y_q, y_d;
    logic             out_valid_q, out_valid_d;
    logic             in_ready_q, in_ready_d;
    logic             busy_q, busy_d;

    logic [5:0]       sq;
    logic [5:0]       prod;
    logic [5:0]       acc_step;

    gf6_mul_red #(.POLY(POLY)) u_sq  (.a(acc_q), .b(acc_q), .p(sq));
    gf6_mul_red #(.POLY(POLY)) u_mul (.a(sq),    .b(x_q),   .p(prod));

    assign acc_step = e_q[cnt_q] ? prod : sq;

`ifdef SMS_EARLY_EXIT_EN
    logic [CNT_W-1:0] msb_idx;

    always_comb begin
        msb_idx = '0;
        for (int i = 0; i < EXP_W; i++) begin
            if (e[i]) msb_idx = CNT_W'(i);
        end
    end
`endif

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        e_d         = e_q;
        t_d         = t_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        y_d         = y_q;
        out_valid_d = out_valid_q;
        in_ready_d  = in_ready_q;
        busy_d      = busy_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    x_d        = x;
                    e_d        = e;
                    t_d        = parity6(x & TMASK);
                    acc_d      = 6'h01;
                    in_ready_d = 1'b0;
                    busy_d     = 1'b1;
`ifdef SMS_EARLY_EXIT_EN
                    if (e == '0) begin
                        cnt_d       = '0;
                        y_d         = 6'h01 ^ {6{t_d}};
                        out_valid_d = 1'b1;
                        state_d     = DONE;
                    end else begin
                        cnt_d   = msb_idx;
                        state_d = RUN;
                    end
`else
                    cnt_d   = CNT_W'(EXP_W - 1);
                    state_d = RUN;
`endif
                end
            end
            RUN: begin
                acc_d = acc_step;
                if (cnt_q == '0) begin
                    y_d         = acc_step ^ {6{t_q}};
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            x_q         <= '0;
            e_q         <= '0;
            t_q         <= 1'b0;
            acc_q       <= '0;
            cnt_q       <= '0;
            y_q         <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            e_q         <= e_d;
            t_q         <= t_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            y_q         <= y_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign y         = y_q;
    assign busy      = busy_q;

endmodule
